egd_bitstream_aligner: RTL and testbench
========================================

// Module: egd_bitstream_aligner
// PURPOSE
//   Bitstream front end for the Exp-Golomb decoder (egd_top_wrapper). Takes packed 16-bit RBSP words
//   from the host over the LA interface and buffers them in a word FIFO. Presents an MSB-first 16-bit
//   window of the next unconsumed bits. Each decode, the decoder reports how many bits it used; the
//   block then advances the window by that amount. Also provides byte-align and flush.
// PARAMETERS
//   WORD_W      16   input word / window width in bits (only 16 supported)
//   FIFO_DEPTH  4    word FIFO entries (power of two)
//   LEN_W       5    width of consume_len (values 0..16)
// PORTS
//   wb_clk_i     in   1       single clock
//   wb_rst_i     in   1       synchronous reset, active-high
//   in_data      in   16      next bitstream word, first bit at [15]
//   in_valid     in   1       in_data valid
//   in_ready     out  1       word accepted on edge where in_valid&&in_ready
//   win_data     out  16      next 16 unconsumed bits, oldest at [15]
//   win_valid    out  1       bits_avail >= 16
//   consume_en   in   1       advance window by consume_len this edge
//   consume_len  in   LEN_W   bits to discard (0..16)
//   align_en     in   1       discard bits up to next byte boundary
//   flush        in   1       clear all buffered data
//   bits_avail   out  6       bits held in bit buffer (0..32)
//   fifo_level   out  3       words in FIFO (0..FIFO_DEPTH)
//   err          out  1       sticky protocol error
// BEHAVIOUR
//   Reset (and flush): FIFO empty, bit buffer = 32'h0, bits_avail = 0, bit_pos = 0, err = 0.
//     Outputs after reset: win_data = 0, win_valid = 0, in_ready = 1, fifo_level = 0.
//   Bit buffer buf[31:0] is MSB-aligned with count cnt; win_data = buf[31:16] (combinational).
//   in_ready = !fifo_full && !flush. There is no FIFO bypass: a word accepted at edge N reaches buf
//     at edge N+1 at the earliest.
//   Per-edge update, with priority flush > align_en > consume_en:
//     1. Consume (consume_en, win_valid=1, consume_len<=16): buf <<= len; cnt -= len;
//        bit_pos = (bit_pos + len) mod 8.
//     2. Align (align_en, win_valid=1): len = (8 - bit_pos) mod 8, then apply as in step 1.
//        If bit_pos = 0, nothing changes.
//     3. Refill, using cnt' = cnt after step 1/2: if cnt' <= 16 and the FIFO is non-empty, pop one word;
//        buf[31-cnt' -: 16] = word; cnt = cnt' + 16.
//        Refill runs in the same edge as consume, so back-to-back 16-bit consumes sustain win_valid.
//   Errors (err is set sticky; state is left unchanged for that edge):
//     - consume_en or align_en while win_valid = 0
//     - consume_len > 16
//     - consume_en and align_en both high (the align is performed, err is set)
//   FIFO: a push on a full FIFO is impossible (in_ready = 0). A push and a pop in the same edge are
//     both allowed; the level is unchanged.
//   Flush mid-operation: everything is cleared at that edge. in_data presented in the flush cycle is
//     dropped. err is cleared.
//   Bits below cnt in buf are always 0; the shift fills with zeros.
// STRUCTURE
//   egd_pkg: EGD_WORD_W=16, EGD_LEN_W=5, EGD_BUF_W=32, and the bits_avail width localparam.
//   Sub-module egd_word_fifo: sync FIFO with push/pop/full/empty/level, sync reset, registered storage.
//   The top level holds the bit buffer, the shifter/merge datapath, cnt, bit_pos and err.
// TESTING
//   T1 Reset, then push 0xA5F0 at edge N: win_valid=1 and win_data=0xA5F0 after edge N+1;
//      bits_avail=16.
//   T2 Push 0xE123, 0x4567; wait until bits_avail=32; consume 3: win_data=0x091A, bits_avail=29,
//      bit_pos=3.
//   T3 Continuation of T2 state: align_en: 5 bits dropped, bits_avail=24, bit_pos=0,
//      win_data=0x2345.
//   T4 cnt=16, FIFO holds 0x1234; consume 16: win_valid stays 1, next cycle win_data=0x1234,
//      bits_avail=16.
//   T5 Stream 7 words with no consumes: 6 accepted (2 in buf, 4 in FIFO); in_ready=0 with
//      fifo_level=4. Then consume 16: FIFO pops one word into buf and in_ready returns to 1.
//   T6 Consume 5 with bits_avail=0, then consume_len=17: err=1 and state unchanged. Then flush:
//      err=0, bits_avail=0, fifo_level=0.

Source files
------------

// File: rtl/egd_bitstream_aligner_pkg.sv
// Shared widths and types for the Exp-Golomb bitstream aligner.
//   EGD_WORD_W      input word / window width
//   EGD_LEN_W       consume_len width (values 0..16)
//   EGD_BUF_W       bit buffer width (two words)
//   EGD_CNT_W       bits_avail width (0..32)
//   EGD_FIFO_DEPTH  word FIFO entries (power of two)
//   EGD_LVL_W       fifo_level width (0..EGD_FIFO_DEPTH)
package egd_bitstream_aligner_pkg;
  localparam int EGD_WORD_W     = 16;
  localparam int EGD_LEN_W      = 5;
  localparam int EGD_BUF_W      = 32;
  localparam int EGD_CNT_W      = $clog2(EGD_BUF_W + 1);
  localparam int EGD_FIFO_DEPTH = 4;
  localparam int EGD_LVL_W      = $clog2(EGD_FIFO_DEPTH + 1);

  // What the bit buffer does on a given edge (flush is handled separately).
  typedef enum logic [1:0] {
    OP_IDLE,
    OP_CONSUME,
    OP_ALIGN,
    OP_HOLD
  } egd_op_e;
endpackage

// File: rtl/egd_bitstream_aligner_if.sv
// Host/decoder-facing signals of the bitstream aligner.
//   master : host + decoder side (drives words and consume/align/flush)
//   slave  : aligner side (drives in_ready, window and status)
interface egd_bitstream_aligner_if;
  import egd_bitstream_aligner_pkg::*;

  logic [EGD_WORD_W-1:0] in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic [EGD_WORD_W-1:0] win_data;
  logic                  win_valid;
  logic                  consume_en;
  logic [EGD_LEN_W-1:0]  consume_len;
  logic                  align_en;
  logic                  flush;
  logic [EGD_CNT_W-1:0]  bits_avail;
  logic [EGD_LVL_W-1:0]  fifo_level;
  logic                  err;

  modport master (
    output in_data, in_valid, consume_en, consume_len, align_en, flush,
    input  in_ready, win_data, win_valid, bits_avail, fifo_level, err
  );

  modport slave (
    input  in_data, in_valid, consume_en, consume_len, align_en, flush,
    output in_ready, win_data, win_valid, bits_avail, fifo_level, err
  );
endinterface

// File: rtl/egd_word_fifo.sv
// Synchronous word FIFO with registered storage and first-word-fall-through
// read data (rdata shows the head entry whenever !empty).
//   clk, rst      clock, synchronous active-high reset
//   clr           synchronous clear (same effect as reset)
//   push, wdata   write one word (caller guarantees !full)
//   pop, rdata    remove head word (caller guarantees !empty)
//   full, empty   status
//   level         number of stored words
module egd_word_fifo #(
  parameter  int W     = 16,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          push,
  input  logic [W-1:0]  wdata,
  input  logic          pop,
  output logic [W-1:0]  rdata,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level
);
  logic [DEPTH-1:0][W-1:0] mem;
  logic [AW-1:0]           wr_ptr, rd_ptr;
  logic [LW-1:0]           level_q;

  // Storage needs no reset; only pointers and level define contents.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      level_q <= level_q + LW'(push) - LW'(pop);
    end
  end

  assign rdata = mem[rd_ptr];
  assign level = level_q;
  assign full  = (level_q == LW'(DEPTH));
  assign empty = (level_q == '0);
endmodule

// File: rtl/egd_bitstream_aligner.sv
// Bitstream front end for the Exp-Golomb decoder. Buffers host words in a
// small FIFO and keeps an MSB-aligned 32-bit bit buffer whose top 16 bits
// form the decode window. Consume/align shift the buffer left; a FIFO word
// is merged in directly below the remaining bits on the same edge.
//   wb_clk_i   clock
//   wb_rst_i   synchronous active-high reset
//   bus        slave side of egd_bitstream_aligner_if (word input,
//              window output, consume/align/flush, status)
module egd_bitstream_aligner
  import egd_bitstream_aligner_pkg::*;
(
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_i,
  egd_bitstream_aligner_if.slave   bus
);
  logic [EGD_BUF_W-1:0]  buf_q, buf_sh, buf_nxt, refill_word;
  logic [EGD_CNT_W-1:0]  cnt_q, cnt_sh, cnt_nxt;
  logic [2:0]            pos_q, align_amt;
  logic                  err_q, err_evt;
  logic                  win_valid;
  logic [EGD_LEN_W-1:0]  drop_len;
  egd_op_e               op;

  logic                  fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [EGD_WORD_W-1:0] fifo_rdata;
  logic [EGD_LVL_W-1:0]  fifo_level;

  assign win_valid    = (cnt_q >= EGD_CNT_W'(EGD_WORD_W));
  assign bus.in_ready = !fifo_full && !bus.flush;
  assign fifo_push    = bus.in_valid && bus.in_ready;

  egd_word_fifo #(
    .W     (EGD_WORD_W),
    .DEPTH (EGD_FIFO_DEPTH)
  ) u_fifo (
    .clk   (wb_clk_i),
    .rst   (wb_rst_i),
    .clr   (bus.flush),
    .push  (fifo_push),
    .wdata (bus.in_data),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  // (8 - pos) mod 8 is just the 3-bit negation of pos.
  assign align_amt = 3'd0 - pos_q;

  always_comb begin
    err_evt = ((bus.consume_en || bus.align_en) && !win_valid) ||
              (bus.consume_en && (bus.consume_len > EGD_LEN_W'(EGD_WORD_W))) ||
              (bus.consume_en && bus.align_en);

    // A legal align wins even when it is itself part of an error (both
    // enables high); any other error freezes the buffer for this edge.
    if (bus.align_en && win_valid) op = OP_ALIGN;
    else if (err_evt)              op = OP_HOLD;
    else if (bus.consume_en)       op = OP_CONSUME;
    else                           op = OP_IDLE;

    case (op)
      OP_ALIGN:   drop_len = {2'b00, align_amt};
      OP_CONSUME: drop_len = bus.consume_len;
      default:    drop_len = '0;
    endcase

    buf_sh = buf_q << drop_len;
    cnt_sh = cnt_q - EGD_CNT_W'(drop_len);

    // Refill uses the post-shift count so a 16-bit consume and a pop share
    // one edge and the window stays valid.
    fifo_pop    = (op != OP_HOLD) && !bus.flush && !fifo_empty &&
                  (cnt_sh <= EGD_CNT_W'(EGD_WORD_W));
    refill_word = {fifo_rdata, {EGD_WORD_W{1'b0}}} >> cnt_sh;

    buf_nxt = buf_sh;
    cnt_nxt = cnt_sh;
    if (fifo_pop) begin
      buf_nxt = buf_sh | refill_word;
      cnt_nxt = cnt_sh + EGD_CNT_W'(EGD_WORD_W);
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i || bus.flush) begin
      buf_q <= '0;
      cnt_q <= '0;
      pos_q <= '0;
      err_q <= 1'b0;
    end else begin
      buf_q <= buf_nxt;
      cnt_q <= cnt_nxt;
      pos_q <= pos_q + drop_len[2:0];
      err_q <= err_q | err_evt;
    end
  end

  assign bus.win_data   = buf_q[EGD_BUF_W-1 -: EGD_WORD_W];
  assign bus.win_valid  = win_valid;
  assign bus.bits_avail = cnt_q;
  assign bus.fifo_level = fifo_level;
  assign bus.err        = err_q;
endmodule

// File: tb/tb_egd_bitstream_aligner.sv
// Directed + randomized checks of egd_bitstream_aligner against a bit-queue
// reference model (buffer as a queue of bits, FIFO as a queue of words).
module tb_egd_bitstream_aligner;
  import egd_bitstream_aligner_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  egd_bitstream_aligner_if bus();
  egd_bitstream_aligner dut (.wb_clk_i(clk), .wb_rst_i(rst), .bus(bus));

  int total = 0;
  int bad   = 0;

  // Reference model state
  bit          mq[$];   // buffered bits, oldest first
  logic [15:0] mf[$];   // FIFO words
  int          mpos;    // total bits discarded mod 8
  bit          merr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] m_win();
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) r[15-i] = (i < mq.size()) ? mq[i] : 1'b0;
    return r;
  endfunction

  function automatic void m_clear();
    mq.delete();
    mf.delete();
    mpos = 0;
    merr = 0;
  endfunction

  // One clock edge of the behavioural rules.
  function automatic void m_edge(input bit v, input logic [15:0] d, input bit ce,
                                 input int cl, input bit ae, input bit fl);
    bit wv, rdy, ev, hold;
    int drop;
    logic [15:0] w;
    if (fl) begin
      m_clear();
      return;
    end
    wv   = (mq.size() >= 16);
    rdy  = (mf.size() < 4);
    ev   = ((ce || ae) && !wv) || (ce && cl > 16) || (ce && ae);
    drop = 0;
    hold = 0;
    if (ae && wv)  drop = (8 - mpos) % 8;
    else if (ev)   hold = 1;
    else if (ce)   drop = cl;
    if (ev) merr = 1;
    if (!hold) begin
      repeat (drop) void'(mq.pop_front());
      mpos = (mpos + drop) % 8;
      if (mq.size() <= 16 && mf.size() > 0) begin
        w = mf.pop_front();
        for (int i = 15; i >= 0; i--) mq.push_back(w[i]);
      end
    end
    if (v && rdy) mf.push_back(d);
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".win_data"},   {16'h0, bus.win_data},   {16'h0, m_win()});
    chk({tag, ".win_valid"},  {31'h0, bus.win_valid},  {31'h0, mq.size() >= 16});
    chk({tag, ".bits_avail"}, {26'h0, bus.bits_avail}, 32'(mq.size()));
    chk({tag, ".fifo_level"}, {29'h0, bus.fifo_level}, 32'(mf.size()));
    chk({tag, ".err"},        {31'h0, bus.err},        {31'h0, merr});
  endtask

  // Drive one cycle of inputs, check in_ready combinationally, then the edge.
  task automatic step(input string tag, input bit v, input logic [15:0] d, input bit ce,
                      input int cl, input bit ae, input bit fl);
    bus.in_valid    = v;
    bus.in_data     = d;
    bus.consume_en  = ce;
    bus.consume_len = cl[4:0];
    bus.align_en    = ae;
    bus.flush       = fl;
    #1;
    chk({tag, ".in_ready"}, {31'h0, bus.in_ready}, {31'h0, (mf.size() < 4) && !fl});
    m_edge(v, d, ce, cl, ae, fl);
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic idle(input string tag);
    step(tag, 0, 16'h0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    rst             = 1'b1;
    bus.in_valid    = 1'b0;
    bus.in_data     = '0;
    bus.consume_en  = 1'b0;
    bus.consume_len = '0;
    bus.align_en    = 1'b0;
    bus.flush       = 1'b0;
    @(posedge clk);
    #1;
    m_clear();
    rst = 1'b0;
    check_all("reset");
  endtask

  initial begin
    int r;
    bit v, ce, ae, fl;
    int cl;

    // Reset values
    do_reset();
    chk("rst.win_data",   {16'h0, bus.win_data},   32'h0);
    chk("rst.win_valid",  {31'h0, bus.win_valid},  32'h0);
    chk("rst.in_ready",   {31'h0, bus.in_ready},   32'h1);
    chk("rst.fifo_level", {29'h0, bus.fifo_level}, 32'h0);

    // T1: word pushed at edge N is in the window after N+1
    step("t1.push", 1, 16'hA5F0, 0, 0, 0, 0);
    chk("t1.n_valid", {31'h0, bus.win_valid}, 32'h0);
    idle("t1.n1");
    chk("t1.win", {16'h0, bus.win_data}, 32'hA5F0);
    chk("t1.bits", {26'h0, bus.bits_avail}, 32'd16);

    // T2: consume 3 from E1234567
    do_reset();
    step("t2.p0", 1, 16'hE123, 0, 0, 0, 0);
    step("t2.p1", 1, 16'h4567, 0, 0, 0, 0);
    for (int i = 0; i < 10 && bus.bits_avail != 6'd32; i++) idle("t2.wait");
    chk("t2.bits32", {26'h0, bus.bits_avail}, 32'd32);
    step("t2.c3", 0, 16'h0, 1, 3, 0, 0);
    chk("t2.win", {16'h0, bus.win_data}, 32'h091A);
    chk("t2.bits", {26'h0, bus.bits_avail}, 32'd29);

    // T3: align drops 5 bits
    step("t3.align", 0, 16'h0, 0, 0, 1, 0);
    chk("t3.win", {16'h0, bus.win_data}, 32'h2345);
    chk("t3.bits", {26'h0, bus.bits_avail}, 32'd24);
    step("t3.align0", 0, 16'h0, 0, 0, 1, 0);
    chk("t3.bits_noop", {26'h0, bus.bits_avail}, 32'd24);

    // T4: consume 16 with refill on the same edge
    do_reset();
    step("t4.p0", 1, 16'hBEEF, 0, 0, 0, 0);
    step("t4.p1", 1, 16'h1234, 0, 0, 0, 0);
    step("t4.c16", 0, 16'h0, 1, 16, 0, 0);
    chk("t4.valid", {31'h0, bus.win_valid}, 32'h1);
    chk("t4.win", {16'h0, bus.win_data}, 32'h1234);
    chk("t4.bits", {26'h0, bus.bits_avail}, 32'd16);

    // T5: fill FIFO until in_ready drops
    do_reset();
    for (int i = 0; i < 7; i++) step("t5.push", 1, 16'(16'h1000 + i), 0, 0, 0, 0);
    bus.in_valid = 1'b0;
    #1;
    chk("t5.level", {29'h0, bus.fifo_level}, 32'd4);
    chk("t5.ready0", {31'h0, bus.in_ready}, 32'h0);
    chk("t5.bits", {26'h0, bus.bits_avail}, 32'd32);
    step("t5.c16", 0, 16'h0, 1, 16, 0, 0);
    chk("t5.ready1", {31'h0, bus.in_ready}, 32'h1);
    chk("t5.level3", {29'h0, bus.fifo_level}, 32'd3);

    // T6: protocol errors and flush
    do_reset();
    step("t6.c_empty", 0, 16'h0, 1, 5, 0, 0);
    chk("t6.err", {31'h0, bus.err}, 32'h1);
    chk("t6.bits0", {26'h0, bus.bits_avail}, 32'd0);
    step("t6.p0", 1, 16'h5A5A, 0, 0, 0, 0);
    idle("t6.fill");
    step("t6.c17", 0, 16'h0, 1, 17, 0, 0);
    chk("t6.hold_win", {16'h0, bus.win_data}, 32'h5A5A);
    chk("t6.hold_bits", {26'h0, bus.bits_avail}, 32'd16);
    step("t6.both", 0, 16'h0, 1, 4, 1, 0);
    step("t6.flush", 1, 16'hFFFF, 0, 0, 0, 1);
    chk("t6.f_err", {31'h0, bus.err}, 32'h0);
    chk("t6.f_bits", {26'h0, bus.bits_avail}, 32'd0);
    chk("t6.f_level", {29'h0, bus.fifo_level}, 32'd0);

    // Randomized traffic against the model
    do_reset();
    for (int n = 0; n < 600; n++) begin
      r  = int'($urandom_range(0, 99));
      v  = ($urandom_range(0, 1) == 1);
      fl = (r < 3);
      ae = (r >= 3 && r < 13);
      ce = (r >= 10 && r < 60);
      cl = ($urandom_range(0, 49) == 0) ? int'($urandom_range(17, 31))
                                        : int'($urandom_range(0, 16));
      step("rnd", v, 16'($urandom), ce, cl, ae, fl);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
